// File: rtl/bram_acc_pkg.sv
// Shared definitions for the BRAM read-sequencer blocks: control FSM state encoding
// and the supported read-latency range.
package bram_acc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned MaxRdLatency = 4;

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid/last shift register matching the BRAM read latency, with synchronous flush.
// empty_o is high when no beat sits behind the output stage, i.e. the pipe is empty next cycle.
module rd_latency_pipe #(
    parameter int unsigned Depth = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o,
    output logic empty_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Depth-1:0] last_q, last_d;

    always_comb begin
        valid_d    = valid_q;
        last_d     = last_q;
        valid_d[0] = valid_i;
        last_d[0]  = last_i & valid_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
            last_d[i]  = last_q[i-1];
        end
    end

    // The output stage is excluded: it leaves the pipe on the coming edge.
    always_comb begin
        empty_o = 1'b1;
        for (int unsigned i = 0; i + 1 < Depth; i++) begin
            if (valid_q[i]) empty_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign last_o  = last_q[Depth-1];

endmodule

// File: rtl/bram_rd_seq_fsm.sv
// BRAM read sequencer: issues cnt_val reads at base + k*stride, optionally looping,
// and returns data aligned with valid/last strobes after the BRAM read latency.
module bram_rd_seq_fsm
    import bram_acc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 31,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  cnt_val_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic                  loop_i,
    input  logic                  stop_i,
    input  logic                  abort_i,
    input  logic                  issue_en_i,
    output logic                  bram_ce_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    input  logic [DATA_WIDTH-1:0] bram_q_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  idle_o,
    output logic                  run_o,
    output logic                  drain_o,
    output logic                  done_o
);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_val_q, cnt_val_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic                  loop_q, loop_d;
    logic                  stop_q, stop_d;

    logic issue;
    logic final_issue;
    logic flush;
    logic pipe_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_val_d   = cnt_val_q;
        addr_d      = addr_q;
        base_d      = base_q;
        stride_d    = stride_q;
        loop_d      = loop_q;
        stop_d      = stop_q;
        issue       = 1'b0;
        final_issue = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_val_d = cnt_val_i;
                    base_d    = base_addr_i;
                    stride_d  = stride_i;
                    loop_d    = loop_i;
                    stop_d    = 1'b0;
                    cnt_d     = '0;
                    addr_d    = base_addr_i;
                    state_d   = (cnt_val_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (stop_i) stop_d = 1'b1;
                    if (issue_en_i) begin
                        issue = 1'b1;
                        if (cnt_q == cnt_val_q - CNT_WIDTH'(1)) begin
                            final_issue = 1'b1;
                            // A stop raised on the final beat still ends this pass.
                            if (!loop_q || stop_q || stop_i) begin
                                state_d = StDrain;
                            end else begin
                                cnt_d  = '0;
                                addr_d = base_q;
                            end
                        end else begin
                            cnt_d  = cnt_q + CNT_WIDTH'(1);
                            addr_d = addr_q + stride_q;
                        end
                    end
                end
            end
            StDrain: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (pipe_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cnt_val_q <= '0;
            addr_q    <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_val_q <= cnt_val_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
        end
    end

    rd_latency_pipe #(
        .Depth (RD_LATENCY)
    ) u_rd_latency_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .valid_i (issue),
        .last_i  (final_issue),
        .valid_o (rd_valid_o),
        .last_o  (rd_last_o),
        .empty_o (pipe_empty)
    );

    assign bram_ce_o   = issue;
    assign bram_addr_o = addr_q;
    assign rd_data_o   = bram_q_i;
    assign cnt_o       = cnt_q;
    assign idle_o      = (state_q == StIdle);
    assign run_o       = (state_q == StRun);
    assign drain_o     = (state_q == StDrain);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_bram_rd_seq_fsm.sv
// Bench for bram_rd_seq_fsm: two instances (read latency 1 and 3) share stimulus; expected
// addresses and beats are queued when a pass is launched and popped as the DUTs produce them.
module tb_bram_rd_seq_fsm;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 31;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_i    = 1'b0;
    logic [CW-1:0] cnt_val_i  = '0;
    logic [AW-1:0] base_i     = '0;
    logic [AW-1:0] stride_i   = '0;
    logic          loop_i     = 1'b0;
    logic          stop_i     = 1'b0;
    logic          abort_i    = 1'b0;
    logic          issue_en_i = 1'b1;

    logic [1:0]    ce_w, valid_w, last_w, idle_w, run_w, drain_w, done_w;
    logic [AW-1:0] addr_w [2];
    logic [DW-1:0] data_w [2];
    logic [CW-1:0] cnt_w  [2];

    logic [DW-1:0] mem0_q;
    logic [DW-1:0] mem1_q [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cnt       [2];
    int done_cyc       [2];
    int first_ce_cyc   [2];
    int last_valid_cyc [2];

    logic [AW-1:0] exp_addr_q [2][$];
    beat_t         exp_beat_q [2][$];

    bram_rd_seq_fsm #(
        .CNT_WIDTH  (CW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (1)
    ) u_dut_l1 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cnt_val_i   (cnt_val_i),
        .base_addr_i (base_i),
        .stride_i    (stride_i),
        .loop_i      (loop_i),
        .stop_i      (stop_i),
        .abort_i     (abort_i),
        .issue_en_i  (issue_en_i),
        .bram_ce_o   (ce_w[0]),
        .bram_addr_o (addr_w[0]),
        .bram_q_i    (mem0_q),
        .rd_data_o   (data_w[0]),
        .rd_valid_o  (valid_w[0]),
        .rd_last_o   (last_w[0]),
        .cnt_o       (cnt_w[0]),
        .idle_o      (idle_w[0]),
        .run_o       (run_w[0]),
        .drain_o     (drain_w[0]),
        .done_o      (done_w[0])
    );

    bram_rd_seq_fsm #(
        .CNT_WIDTH  (CW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (3)
    ) u_dut_l3 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .cnt_val_i   (cnt_val_i),
        .base_addr_i (base_i),
        .stride_i    (stride_i),
        .loop_i      (loop_i),
        .stop_i      (stop_i),
        .abort_i     (abort_i),
        .issue_en_i  (issue_en_i),
        .bram_ce_o   (ce_w[1]),
        .bram_addr_o (addr_w[1]),
        .bram_q_i    (mem1_q[2]),
        .rd_data_o   (data_w[1]),
        .rd_valid_o  (valid_w[1]),
        .rd_last_o   (last_w[1]),
        .cnt_o       (cnt_w[1]),
        .idle_o      (idle_w[1]),
        .run_o       (run_w[1]),
        .drain_o     (drain_w[1]),
        .done_o      (done_w[1])
    );

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // BRAM models: latency 1 and a 3-deep output pipeline.
    always @(posedge clk) begin
        if (ce_w[0]) mem0_q <= mem_word(addr_w[0]);
        if (ce_w[1]) mem1_q[0] <= mem_word(addr_w[1]);
        mem1_q[1] <= mem1_q[0];
        mem1_q[2] <= mem1_q[1];
        cyc <= cyc + 1;
    end

    task automatic check_eq(string tag, longint unsigned got, longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [AW-1:0] a;
        beat_t         b;
        for (int k = 0; k < 2; k++) begin
            if (ce_w[k]) begin
                if (first_ce_cyc[k] < 0) first_ce_cyc[k] = cyc;
                check_eq($sformatf("issue_expected[%0d]", k), exp_addr_q[k].size() != 0, 1);
                if (exp_addr_q[k].size() != 0) begin
                    a = exp_addr_q[k].pop_front();
                    check_eq($sformatf("bram_addr[%0d]", k), addr_w[k], a);
                end
            end
            if (valid_w[k]) begin
                if (last_w[k]) last_valid_cyc[k] = cyc;
                check_eq($sformatf("beat_expected[%0d]", k), exp_beat_q[k].size() != 0, 1);
                if (exp_beat_q[k].size() != 0) begin
                    b = exp_beat_q[k].pop_front();
                    check_eq($sformatf("rd_data[%0d]", k), data_w[k], mem_word(b.addr));
                    check_eq($sformatf("rd_last[%0d]", k), last_w[k], b.last);
                end
            end
            if (done_w[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        for (int k = 0; k < 2; k++) begin
            done_cnt[k]       = 0;
            done_cyc[k]       = -1;
            first_ce_cyc[k]   = -1;
            last_valid_cyc[k] = -1;
        end
    endtask

    task automatic push_addr(int k, logic [AW-1:0] a, logic has_beat, logic last);
        beat_t b;
        exp_addr_q[k].push_back(a);
        if (has_beat) begin
            b.addr = a;
            b.last = last;
            exp_beat_q[k].push_back(b);
        end
    endtask

    task automatic push_pass(logic [AW-1:0] base, logic [AW-1:0] stride, int n);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) push_addr(k, a, 1'b1, i == n - 1);
            a = a + stride;
        end
    endtask

    // Leaves the bench in the cycle right after the start cycle.
    task automatic start_pass(int cnt, logic [AW-1:0] base, logic [AW-1:0] stride, logic lp);
        start_cyc = cyc;
        cnt_val_i = CW'(cnt);
        base_i    = base;
        stride_i  = stride;
        loop_i    = lp;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (idle_w != 2'b11 && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_within_budget", idle_w == 2'b11, 1);
        tick(4);
    endtask

    task automatic end_test(string name, int exp_done, bit timing);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_addrs_left[%0d]", name, k), exp_addr_q[k].size(), 0);
            check_eq($sformatf("%s_beats_left[%0d]", name, k), exp_beat_q[k].size(), 0);
            check_eq($sformatf("%s_done_count[%0d]", name, k), done_cnt[k], exp_done);
            if (timing) begin
                check_eq($sformatf("%s_first_issue_delay[%0d]", name, k),
                         longint'(first_ce_cyc[k] - start_cyc), 1);
                check_eq($sformatf("%s_done_after_last[%0d]", name, k),
                         longint'(done_cyc[k] - last_valid_cyc[k]), 1);
            end
            exp_addr_q[k].delete();
            exp_beat_q[k].delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        begin_test();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_ce[%0d]", k), ce_w[k], 0);
            check_eq($sformatf("rst_addr[%0d]", k), addr_w[k], 0);
            check_eq($sformatf("rst_valid[%0d]", k), valid_w[k], 0);
            check_eq($sformatf("rst_last[%0d]", k), last_w[k], 0);
            check_eq($sformatf("rst_cnt[%0d]", k), cnt_w[k], 0);
            check_eq($sformatf("rst_done[%0d]", k), done_w[k], 0);
            check_eq($sformatf("rst_idle[%0d]", k), idle_w[k], 1);
        end
        tick();
        rst = 1'b0;
        tick(2);

        // One-shot, 4 reads from 0x10.
        begin_test();
        push_pass(16'h0010, 16'h0001, 4);
        start_pass(4, 16'h0010, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("oneshot_ce_contig%0d", i), ce_w, 2'b11);
            tick();
        end
        wait_idle(50);
        end_test("oneshot", 1, 1'b1);

        // Address wrap past the top of the address space.
        begin_test();
        push_pass(16'hFFFE, 16'h0003, 3);
        start_pass(3, 16'hFFFE, 16'h0003, 1'b0);
        wait_idle(50);
        end_test("wrap", 1, 1'b1);

        // Issue stall for two cycles after the first read.
        begin_test();
        push_pass(16'h0100, 16'h0004, 3);
        start_pass(3, 16'h0100, 16'h0004, 1'b0);
        tick();
        issue_en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall_ce%0d", i), ce_w, 2'b00);
            for (int k = 0; k < 2; k++) check_eq($sformatf("stall_cnt%0d[%0d]", i, k), cnt_w[k], 1);
            tick();
        end
        issue_en_i = 1'b1;
        wait_idle(50);
        end_test("stall", 1, 1'b1);

        // Looped passes of 2, stop raised during pass 3.
        begin_test();
        for (int p = 0; p < 3; p++) push_pass(16'h0200, 16'h0010, 2);
        start_pass(2, 16'h0200, 16'h0010, 1'b1);
        tick(4);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wait_idle(50);
        end_test("loop_stop", 1, 1'b1);

        // Abort on the second issue cycle.
        begin_test();
        push_addr(0, 16'h0040, 1'b1, 1'b0);
        push_addr(1, 16'h0040, 1'b0, 1'b0);
        start_pass(5, 16'h0040, 16'h0002, 1'b0);
        tick();
        abort_i = 1'b1;
        @(negedge clk);
        check_eq("abort_ce_blocked", ce_w, 2'b00);
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_next", idle_w, 2'b11);
        wait_idle(50);
        end_test("abort", 0, 1'b0);

        // Zero-length pass goes straight to the done pulse.
        begin_test();
        start_pass(0, 16'h0080, 16'h0001, 1'b0);
        @(negedge clk);
        check_eq("zero_len_done", done_w, 2'b11);
        wait_idle(50);
        end_test("zero_len", 1, 1'b0);

        // start_i during RUN must not recapture the count.
        begin_test();
        push_pass(16'h0300, 16'h0001, 3);
        start_pass(3, 16'h0300, 16'h0001, 1'b0);
        tick();
        cnt_val_i = CW'(7);
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        wait_idle(50);
        end_test("start_in_run", 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
